if_fetch_ctrl: RTL and testbench

IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

---
 rtl/if_fetch_ctrl.sv | 144 ++++++++++++++
 tb/tb_if_fetch_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : if_fetch_ctrl
// Brief   : Instruction fetch controller with a 2-entry prefetch FIFO and
//           branch redirect/discard handling.
// Revision: 1.0
// ============================================================================
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    localparam logic [1:0] c_FULL = 2'd2;

    state_t      r_state;
    logic        r_imem_req;
    logic [1:0]  r_count;
    logic        r_head;
    logic [31:0] r_fifo_instr [2];
    logic [31:0] r_fifo_pc    [2];
    logic [31:0] r_pc;
    logic [31:0] r_req_addr;

    state_t      w_state_nxt;
    logic [31:0] w_req_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_branch_addr;
    logic [31:0] w_seq_addr;
    logic [1:0]  w_count_after;
    logic        w_pop;
    logic        w_push;
    logic        w_wr_idx;

    assign if_valid  = (r_count != 2'd0);
    assign if_instr  = if_valid ? r_fifo_instr[r_head] : 32'd0;
    assign if_pc     = if_valid ? r_fifo_pc[r_head]    : 32'd0;
    assign imem_req  = r_imem_req;
    assign imem_addr = r_req_addr;

    always_comb begin
        w_branch_addr = {branch_addr[31:2], 2'b00};
        w_seq_addr    = r_req_addr + 32'd4;
        w_pop         = if_valid && !freeze && !branch_taken;
        w_push        = (r_state == ST_BUSY) && imem_ack && !branch_taken;
        // Push only happens with count<=1, so this never exceeds 2.
        w_wr_idx      = r_head ^ r_count[0];
        w_count_after = r_count + {1'b0, w_push} - {1'b0, w_pop};
        w_state_nxt   = r_state;
        w_req_nxt     = r_req_addr;
        w_pc_nxt      = r_pc;
        case (r_state)
            ST_IDLE: begin
                if (branch_taken) begin
                    w_state_nxt = ST_BUSY;
                    w_req_nxt   = w_branch_addr;
                    w_pc_nxt    = w_branch_addr;
                end else if (r_count != c_FULL) begin
                    w_state_nxt = ST_BUSY;
                    w_req_nxt   = r_pc;
                end
            end
            ST_BUSY: begin
                if (branch_taken) begin
                    w_pc_nxt = w_branch_addr;
                    if (imem_ack) begin
                        w_state_nxt = ST_BUSY;
                        w_req_nxt   = w_branch_addr;
                    end else begin
                        // Address must stay put until the in-flight access completes.
                        w_state_nxt = ST_DISCARD;
                    end
                end else if (imem_ack) begin
                    w_pc_nxt = w_seq_addr;
                    if (w_count_after != c_FULL) begin
                        w_state_nxt = ST_BUSY;
                        w_req_nxt   = w_seq_addr;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DISCARD: begin
                if (branch_taken) begin
                    w_pc_nxt = w_branch_addr;
                end
                if (imem_ack) begin
                    w_state_nxt = ST_BUSY;
                    w_req_nxt   = branch_taken ? w_branch_addr : r_pc;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_imem_req      <= 1'b0;
            r_count         <= 2'd0;
            r_head          <= 1'b0;
            r_fifo_instr[0] <= 32'd0;
            r_fifo_instr[1] <= 32'd0;
            r_fifo_pc[0]    <= 32'd0;
            r_fifo_pc[1]    <= 32'd0;
            r_pc            <= RESET_PC;
            r_req_addr      <= RESET_PC;
        end else begin
            r_state    <= w_state_nxt;
            r_imem_req <= (w_state_nxt != ST_IDLE);
            r_req_addr <= w_req_nxt;
            r_pc       <= w_pc_nxt;
            r_count    <= branch_taken ? 2'd0 : w_count_after;
            if (w_pop) begin
                r_head <= ~r_head;
            end
            if (w_push) begin
                r_fifo_instr[w_wr_idx] <= imem_rdata;
                r_fifo_pc[w_wr_idx]    <= w_seq_addr;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_ctrl.sv
`default_nettype none
// Directed table-driven bench for if_fetch_ctrl, plus a second instance
// exercising address wrap-around from a high reset PC.
module tb_if_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst, freeze, branch_taken, imem_ack;
    logic [31:0] branch_addr, imem_rdata;
    logic        imem_req, if_valid;
    logic [31:0] imem_addr, if_instr, if_pc;

    logic        rst2, imem_ack2;
    logic [31:0] imem_rdata2;
    logic        imem_req2, if_valid2;
    logic [31:0] imem_addr2, if_instr2, if_pc2;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    if_fetch_ctrl dut (
        .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
        .branch_addr(branch_addr), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_valid(if_valid),
        .if_instr(if_instr), .if_pc(if_pc)
    );

    if_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .rst(rst2), .freeze(1'b0), .branch_taken(1'b0),
        .branch_addr(32'd0), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ack(imem_ack2), .imem_rdata(imem_rdata2), .if_valid(if_valid2),
        .if_instr(if_instr2), .if_pc(if_pc2)
    );

    typedef struct {
        logic        rst, fz, br;
        logic [31:0] baddr;
        logic        ack;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr, pc;
    } vec_t;

    vec_t tv[$];

    localparam logic [31:0] J = 32'hDEAD_BEEF;

    function automatic vec_t v(input logic r, input logic f, input logic b,
                               input logic [31:0] ba, input logic a,
                               input logic [31:0] rd, input logic q,
                               input logic [31:0] ad, input logic vl,
                               input logic [31:0] in, input logic [31:0] p);
        vec_t t;
        t.rst = r; t.fz = f; t.br = b; t.baddr = ba; t.ack = a; t.rdata = rd;
        t.req = q; t.addr = ad; t.valid = vl; t.instr = in; t.pc = p;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk2(input string nm, input logic q, input logic [31:0] ad,
                        input logic vl, input logic [31:0] in, input logic [31:0] p);
        chk({nm, " req2"},   {31'd0, imem_req2}, {31'd0, q});
        chk({nm, " addr2"},  imem_addr2, ad);
        chk({nm, " valid2"}, {31'd0, if_valid2}, {31'd0, vl});
        chk({nm, " instr2"}, if_instr2, in);
        chk({nm, " pc2"},    if_pc2, p);
    endtask

    initial begin
        // Streaming, freeze, resume
        tv.push_back(v(0,0,0,0,    0,J,            0,32'h00,0,0,0));
        tv.push_back(v(0,0,0,0,    1,32'hC0DE0000, 1,32'h00,0,0,0));
        tv.push_back(v(0,0,0,0,    1,32'hC0DE0004, 1,32'h04,1,32'hC0DE0000,32'h04));
        tv.push_back(v(0,0,0,0,    1,32'hC0DE0008, 1,32'h08,1,32'hC0DE0004,32'h08));
        tv.push_back(v(0,0,0,0,    1,32'hC0DE000C, 1,32'h0C,1,32'hC0DE0008,32'h0C));
        tv.push_back(v(0,1,0,0,    1,32'hC0DE0010, 1,32'h10,1,32'hC0DE000C,32'h10));
        for (int i = 0; i < 4; i++)
            tv.push_back(v(0,1,0,0,0,J,            0,32'h10,1,32'hC0DE000C,32'h10));
        tv.push_back(v(0,0,0,0,    0,J,            0,32'h10,1,32'hC0DE000C,32'h10));
        tv.push_back(v(0,0,0,0,    0,J,            0,32'h10,1,32'hC0DE0010,32'h14));
        tv.push_back(v(0,0,0,0,    1,32'hC0DE0014, 1,32'h14,0,0,0));
        tv.push_back(v(0,0,0,0,    0,J,            1,32'h18,1,32'hC0DE0014,32'h18));
        tv.push_back(v(0,0,0,0,    0,J,            1,32'h18,0,0,0));
        // Branch with ack, then branch during wait -> discard
        tv.push_back(v(0,0,1,32'h10,1,J,           1,32'h18,0,0,0));
        tv.push_back(v(0,0,1,32'h40,0,J,           1,32'h10,0,0,0));
        tv.push_back(v(0,0,0,0,    0,J,            1,32'h10,0,0,0));
        tv.push_back(v(0,0,0,0,    1,32'hBAD00010, 1,32'h10,0,0,0));
        tv.push_back(v(0,0,0,0,    0,J,            1,32'h40,0,0,0));
        tv.push_back(v(0,0,0,0,    1,32'hC0DE0040, 1,32'h40,0,0,0));
        tv.push_back(v(0,1,0,0,    0,J,            1,32'h44,1,32'hC0DE0040,32'h44));
        // Branch + ack with count=1 and freeze; unaligned target gets masked
        tv.push_back(v(0,1,1,32'h83,1,32'hBAD00044,1,32'h44,1,32'hC0DE0040,32'h44));
        tv.push_back(v(0,1,0,0,    0,J,            1,32'h80,0,0,0));
        tv.push_back(v(0,0,0,0,    1,32'hC0DE0080, 1,32'h80,0,0,0));
        tv.push_back(v(0,0,0,0,    0,J,            1,32'h84,1,32'hC0DE0080,32'h84));
        // Repeated branches while discarding: only the last target survives
        tv.push_back(v(0,0,1,32'h100,0,J,          1,32'h84,0,0,0));
        tv.push_back(v(0,0,1,32'h200,0,J,          1,32'h84,0,0,0));
        tv.push_back(v(0,0,0,0,    1,32'hBAD00084, 1,32'h84,0,0,0));
        tv.push_back(v(0,0,0,0,    0,J,            1,32'h200,0,0,0));
        // Reset with a request outstanding and data buffered
        tv.push_back(v(0,1,0,0,    1,32'hC0DE0200, 1,32'h200,0,0,0));
        tv.push_back(v(1,1,0,0,    1,J,            1,32'h204,1,32'hC0DE0200,32'h204));
        tv.push_back(v(0,0,0,0,    0,J,            0,32'h00,0,0,0));
        tv.push_back(v(0,0,0,0,    0,J,            1,32'h00,0,0,0));

        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
        imem_ack = 1'b0; imem_rdata = '0;
        rst2 = 1'b1; imem_ack2 = 1'b0; imem_rdata2 = '0;

        @(posedge clk);
        @(negedge clk);
        chk("reset req",   {31'd0, imem_req}, 32'd0);
        chk("reset valid", {31'd0, if_valid}, 32'd0);
        chk("reset instr", if_instr, 32'd0);
        chk("reset pc",    if_pc, 32'd0);
        chk2("reset", 1'b0, 32'hFFFF_FFF8, 1'b0, 32'd0, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (tv[i]) begin
            rst          = tv[i].rst;
            freeze       = tv[i].fz;
            branch_taken = tv[i].br;
            branch_addr  = tv[i].baddr;
            imem_ack     = tv[i].ack;
            imem_rdata   = tv[i].rdata;
            @(negedge clk);
            chk($sformatf("row%0d req", i),   {31'd0, imem_req}, {31'd0, tv[i].req});
            chk($sformatf("row%0d addr", i),  imem_addr, tv[i].addr);
            chk($sformatf("row%0d valid", i), {31'd0, if_valid}, {31'd0, tv[i].valid});
            chk($sformatf("row%0d instr", i), if_instr, tv[i].instr);
            chk($sformatf("row%0d pc", i),    if_pc, tv[i].pc);
            @(posedge clk);
            #1;
        end
        rst = 1'b0; imem_ack = 1'b0; branch_taken = 1'b0; freeze = 1'b0;

        // Wrap-around fetch from RESET_PC = FFFF_FFF8 with zero-wait memory
        rst2 = 1'b0;
        @(negedge clk);
        chk2("wrapA", 1'b0, 32'hFFFF_FFF8, 1'b0, 32'd0, 32'd0);
        @(posedge clk); #1;
        imem_ack2 = 1'b1; imem_rdata2 = 32'h1234_0008;
        @(negedge clk);
        chk2("wrapB", 1'b1, 32'hFFFF_FFF8, 1'b0, 32'd0, 32'd0);
        @(posedge clk); #1;
        imem_rdata2 = 32'h1234_000C;
        @(negedge clk);
        chk2("wrapC", 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h1234_0008, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        imem_rdata2 = 32'h1234_0010;
        @(negedge clk);
        chk2("wrapD", 1'b1, 32'h0000_0000, 1'b1, 32'h1234_000C, 32'h0000_0000);
        @(posedge clk); #1;
        imem_ack2 = 1'b0; imem_rdata2 = J;
        @(negedge clk);
        chk2("wrapE", 1'b1, 32'h0000_0004, 1'b1, 32'h1234_0010, 32'h0000_0004);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
